// File: rtl/mem_bus_pkg.sv
// Shared types for the memory arbiter: FSM states, master indices, mask-width helper.
// ERR state exists only when MEM_ARB_TIMEOUT_EN is defined.
// Pure declarations; no latency or backpressure of its own.
package mem_bus_pkg;

`ifdef MEM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
`endif

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    function automatic int mask_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin pick; one-hot grant, req[0]=IFU, req[1]=LSU.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the master that did not win last time goes first.
        if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU to single memory port arbiter, one transaction outstanding, round-robin grants.
// Latency: grant in IDLE, mem_req_valid next cycle, response forwarded combinationally (min 3 cycles).
// Backpressure: req_ready only in IDLE; response held while master stalls. MEM_ARB_TIMEOUT_EN adds a watchdog.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [ADDR_W-1:0]         ifu_addr,
    output logic                      ifu_resp_valid,
    input  logic                      ifu_resp_ready,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [ADDR_W-1:0]         lsu_addr,
    input  logic                      lsu_wen,
    input  logic [DATA_W-1:0]         lsu_wdata,
    input  logic [mask_w(DATA_W)-1:0] lsu_wmask,
    output logic                      lsu_resp_valid,
    input  logic                      lsu_resp_ready,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wen,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [mask_w(DATA_W)-1:0] mem_wmask,
    input  logic                      mem_resp_valid,
    output logic                      mem_resp_ready,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int MW = mask_w(DATA_W);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t              state;
    logic                gnt;
    logic                last_gnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MW-1:0]       wmask_q;
    logic [1:0]          pick;
    logic                gnt_resp_ready;
    logic                resp_done;
    logic                resp_any;

    arb_rr2 u_arb (
        .req      ({lsu_req_valid, ifu_req_valid}),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    assign ifu_req_ready  = (state == IDLE) && pick[0];
    assign lsu_req_ready  = (state == IDLE) && pick[1];
    assign gnt_resp_ready = (gnt == MST_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign resp_done      = (state == RESP) && mem_resp_valid && gnt_resp_ready;

    assign mem_req_valid  = (state == REQ);
    assign mem_resp_ready = (state == RESP) && gnt_resp_ready;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Hit fires on the last cycle of the allowed window so ERR starts right after it.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_any    = ((state == RESP) && mem_resp_valid) || (state == ERR);
    assign resp_rdata  = (state == ERR) ? '0 : mem_rdata;
    assign resp_err    = (state == ERR);
`else
    assign resp_any    = (state == RESP) && mem_resp_valid;
    assign resp_rdata  = mem_rdata;
    assign resp_err    = 1'b0;
`endif

    assign ifu_resp_valid = resp_any && (gnt == MST_IFU);
    assign lsu_resp_valid = resp_any && (gnt == MST_LSU);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= MST_IFU;
            last_gnt <= MST_LSU;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|pick) begin
                        gnt      <= pick[1];
                        last_gnt <= pick[1];
                        state    <= REQ;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt      <= '0;
`endif
                        if (pick[1]) begin
                            addr_q  <= lsu_addr;
                            wen_q   <= lsu_wen;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                        end else begin
                            addr_q  <= ifu_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                REQ: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
                    if (timeout_hit)        state <= ERR;
                    else if (mem_req_ready) state <= RESP;
`else
                    if (mem_req_ready) state <= RESP;
`endif
                end
                RESP: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
                    if (resp_done)        state <= IDLE;
                    else if (timeout_hit) state <= ERR;
`else
                    if (resp_done) state <= IDLE;
`endif
                end
`ifdef MEM_ARB_TIMEOUT_EN
                ERR: begin
                    if (gnt_resp_ready) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// With MEM_ARB_TIMEOUT_EN defined the watchdog scenario is exercised as well.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [AW-1:0] ifu_addr;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [MW-1:0] lsu_wmask;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        settle();
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b want 000000",
                     {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready});
        end
        checks++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_mem_fields: addr %h wen %b wdata %h wmask %h want all 0", mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        checks++;
        if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        rst = 0;
    endtask

    task automatic test_ifu_single;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        settle();
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin
            errors++; $display("FAIL single_cycle0: ifu_rdy/lsu_rdy/mreq got %b want 100", {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
        tick();
        ifu_req_valid = 0;
        settle();
        // mem_resp_valid is already high here; it must be ignored while the request is pending.
        checks++;
        if ({mem_req_valid, ifu_resp_valid} !== 2'b10) begin
            errors++; $display("FAIL single_cycle1_valid: mreq/ifu_resp got %b want 10", {mem_req_valid, ifu_resp_valid});
        end
        checks++;
        if (mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== '0) begin
            errors++; $display("FAIL single_cycle1_fields: addr %h wen %b wmask %h want 80000000 0 0", mem_addr, mem_wen, mem_wmask);
        end
        tick();
        settle();
        checks++;
        if (ifu_resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0413 || resp_err !== 1'b0) begin
            errors++; $display("FAIL single_cycle2_resp: valid %b rdata %h err %b want 1 00000413 0", ifu_resp_valid, resp_rdata, resp_err);
        end
        checks++;
        if (lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            errors++; $display("FAIL single_cycle2_side: lsu_resp %b mem_resp_ready %b want 0 1", lsu_resp_valid, mem_resp_ready);
        end
        tick();
        mem_resp_valid = 0;
        settle();
        checks++;
        if ({ifu_resp_valid, mem_req_valid} !== 2'b00) begin
            errors++; $display("FAIL single_done: ifu_resp/mreq got %b want 00", {ifu_resp_valid, mem_req_valid});
        end
    endtask

    task automatic test_round_robin;
        int n = 0;
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_wen = 0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h5555_aaaa;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            settle();
            if (ifu_req_ready || lsu_req_ready) begin
                checks++;
                // Expected order starting from reset: IFU, LSU, IFU, ...
                if ({lsu_req_ready, ifu_req_ready} !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: lsu/ifu ready got %b want %b", n, {lsu_req_ready, ifu_req_ready},
                             (n % 2 == 0) ? 2'b01 : 2'b10);
                end
                n++;
            end
            tick();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        checks++;
        if (n != 6) begin errors++; $display("FAIL rr_count: got %0d grants want 6 within budget", n); end
        tick(); tick(); tick();
        mem_resp_valid = 0;
        settle();
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
            errors++; $display("FAIL rr_drain: mreq/ifu_resp/lsu_resp got %b want 000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
    endtask

    task automatic test_store_stall;
        mem_req_ready = 0; mem_resp_valid = 0;
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
        settle();
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            errors++; $display("FAIL store_grant: lsu/ifu ready got %b want 10", {lsu_req_ready, ifu_req_ready});
        end
        tick();
        lsu_req_valid = 0; lsu_wdata = '0; lsu_addr = '0; lsu_wmask = '0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'h3) begin
                errors++;
                $display("FAIL store_hold%0d: v %b addr %h wen %b wdata %h wmask %h want 1 80001000 1 deadbeef 3",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
            end
            checks++;
            if ({lsu_req_ready, ifu_req_ready} !== 2'b00) begin
                errors++; $display("FAIL store_busy%0d: lsu/ifu ready got %b want 00", i, {lsu_req_ready, ifu_req_ready});
            end
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
    endtask

    task automatic test_resp_stall;
        mem_resp_valid = 1; mem_rdata = 32'h1234_5678; lsu_resp_ready = 0; ifu_resp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({lsu_resp_valid, ifu_resp_valid, mem_resp_ready, ifu_req_ready} !== 4'b1000 || resp_rdata !== 32'h1234_5678) begin
                errors++;
                $display("FAIL resp_stall%0d: lsu_resp/ifu_resp/mem_rdy/ifu_rdy got %b rdata %h want 1000 12345678",
                         i, {lsu_resp_valid, ifu_resp_valid, mem_resp_ready, ifu_req_ready}, resp_rdata);
            end
            tick();
        end
        lsu_resp_ready = 1;
        settle();
        checks++;
        if ({lsu_resp_valid, mem_resp_ready} !== 2'b11) begin
            errors++; $display("FAIL resp_release: lsu_resp/mem_rdy got %b want 11", {lsu_resp_valid, mem_resp_ready});
        end
        tick();
        mem_resp_valid = 0;
        settle();
        checks++;
        if ({lsu_resp_valid, ifu_req_ready} !== 2'b01) begin
            errors++; $display("FAIL resp_complete: lsu_resp/ifu_rdy got %b want 01", {lsu_resp_valid, ifu_req_ready});
        end
    endtask

    task automatic test_reset_mid;
        tick();
        settle();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0040) begin
            errors++; $display("FAIL rstmid_req: v %b addr %h want 1 80000040", mem_req_valid, mem_addr);
        end
        rst = 1; ifu_req_valid = 0;
        tick();
        settle();
        checks++;
        if (mem_req_valid !== 1'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL rstmid_idle: v %b addr %h want 0 00000000", mem_req_valid, mem_addr);
        end
        rst = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
        settle();
        checks++;
        if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_regrant: ifu_rdy got %b want 1", ifu_req_ready); end
        tick();
        ifu_req_valid = 0;
        settle();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0080) begin
            errors++; $display("FAIL rstmid_newreq: v %b addr %h want 1 80000080", mem_req_valid, mem_addr);
        end
        mem_req_ready = 1; mem_resp_valid = 1; ifu_resp_ready = 1;
        tick(); tick();
        idle_inputs();
    endtask

    // Transaction-level model: pending masters, whose turn it is, and one outstanding transfer.
    task automatic test_random;
        int phase = 0;          // 0 free, 1 request at memory, 2 awaiting response
        bit owner = 0, last_w = 1;
        bit ifu_pend = 0, lsu_pend = 0, ifu_wait = 0, lsu_wait = 0;
        bit acc_i, acc_l, done;
        bit exp_i, exp_l, own_rdy;
        int age = 0, grants = 0;
        logic [AW-1:0] e_addr;
        logic e_wen;
        logic [DW-1:0] e_wdata;
        logic [MW-1:0] e_wmask;
        do_reset();
        for (int cyc = 0; cyc < 600 && errors < 20; cyc++) begin
            if (!ifu_pend && !ifu_wait && $urandom_range(2) == 0) begin
                ifu_pend = 1; ifu_req_valid = 1; ifu_addr = $urandom;
            end
            if (!lsu_pend && !lsu_wait && $urandom_range(2) == 0) begin
                lsu_pend = 1; lsu_req_valid = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
                lsu_wdata = $urandom; lsu_wmask = MW'($urandom);
            end
            ifu_resp_ready = ($urandom_range(3) != 0);
            lsu_resp_ready = ($urandom_range(3) != 0);
            mem_req_ready = 1'($urandom) || (age >= 3);
            if (phase == 2 && !mem_resp_valid && ($urandom_range(1) == 0 || age >= 4)) begin
                mem_resp_valid = 1; mem_rdata = $urandom;
            end
            if (phase == 2 && age >= 4) begin ifu_resp_ready = 1; lsu_resp_ready = 1; end
            settle();

            exp_i = 0; exp_l = 0;
            if (phase == 0) begin
                if (ifu_pend && lsu_pend) begin exp_i = last_w; exp_l = !last_w; end
                else begin exp_i = ifu_pend; exp_l = lsu_pend; end
            end
            checks++;
            if ({lsu_req_ready, ifu_req_ready} !== {exp_l, exp_i}) begin
                errors++; $display("FAIL rand_ready c%0d: lsu/ifu got %b want %b", cyc, {lsu_req_ready, ifu_req_ready}, {exp_l, exp_i});
            end
            checks++;
            if (mem_req_valid !== (phase == 1)) begin
                errors++; $display("FAIL rand_mreq c%0d: got %b want %b", cyc, mem_req_valid, phase == 1);
            end
            if (phase == 1) begin
                checks++;
                if (mem_addr !== e_addr || mem_wen !== e_wen || mem_wdata !== e_wdata || mem_wmask !== e_wmask) begin
                    errors++;
                    $display("FAIL rand_fields c%0d: got %h %b %h %h want %h %b %h %h", cyc, mem_addr, mem_wen, mem_wdata,
                             mem_wmask, e_addr, e_wen, e_wdata, e_wmask);
                end
            end
            own_rdy = owner ? lsu_resp_ready : ifu_resp_ready;
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !==
                {phase == 2 && !owner && mem_resp_valid, phase == 2 && owner && mem_resp_valid, phase == 2 && own_rdy}) begin
                errors++;
                $display("FAIL rand_resp c%0d: ifu/lsu/mem_rdy got %b want %b", cyc,
                         {ifu_resp_valid, lsu_resp_valid, mem_resp_ready},
                         {phase == 2 && !owner && mem_resp_valid, phase == 2 && owner && mem_resp_valid, phase == 2 && own_rdy});
            end
            if (phase == 2 && mem_resp_valid) begin
                checks++;
                if (resp_rdata !== mem_rdata || resp_err !== 1'b0) begin
                    errors++; $display("FAIL rand_rdata c%0d: got %h err %b want %h 0", cyc, resp_rdata, resp_err, mem_rdata);
                end
            end

            acc_i = 0; acc_l = 0; done = 0;
            age++;
            if (phase == 0 && (exp_i || exp_l)) begin
                owner = exp_l; last_w = exp_l; phase = 1; age = 0; grants++;
                if (exp_l) begin
                    acc_l = 1; lsu_pend = 0; lsu_wait = 1;
                    e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wmask = lsu_wmask;
                end else begin
                    acc_i = 1; ifu_pend = 0; ifu_wait = 1;
                    e_addr = ifu_addr; e_wen = 0; e_wdata = '0; e_wmask = '0;
                end
            end else if (phase == 1 && mem_req_ready) begin
                phase = 2;
            end else if (phase == 2 && mem_resp_valid && own_rdy) begin
                phase = 0; done = 1;
                if (owner) lsu_wait = 0; else ifu_wait = 0;
            end
            tick();
            if (acc_i) ifu_req_valid = 0;
            if (acc_l) lsu_req_valid = 0;
            if (done) mem_resp_valid = 0;
        end
        checks++;
        if (grants < 30) begin errors++; $display("FAIL rand_progress: got %0d grants want at least 30", grants); end
        idle_inputs();
        tick(); tick(); tick(); tick(); tick(); tick();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int c = 0;
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h0000_0100; mem_rdata = 32'hCAFE_F00D;
        tick();
        ifu_req_valid = 0;
        settle();
        while (!ifu_resp_valid && c < 30) begin
            tick();
            c++;
        end
        // TO cycles spent waiting after acceptance, then the error response appears.
        checks++;
        if (c != TO) begin errors++; $display("FAIL timeout_latency: resp after %0d cycles want %0d", c + 1, TO + 1); end
        checks++;
        if ({ifu_resp_valid, resp_err, mem_req_valid, lsu_resp_valid} !== 4'b1100 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL timeout_resp: ifu_resp/err/mreq/lsu_resp got %b rdata %h want 1100 00000000",
                     {ifu_resp_valid, resp_err, mem_req_valid, lsu_resp_valid}, resp_rdata);
        end
        tick();
        checks++;
        if ({ifu_resp_valid, resp_err} !== 2'b11) begin
            errors++; $display("FAIL timeout_hold: ifu_resp/err got %b want 11", {ifu_resp_valid, resp_err});
        end
        ifu_resp_ready = 1;
        tick();
        ifu_resp_ready = 0; ifu_req_valid = 1;
        settle();
        checks++;
        if ({ifu_resp_valid, resp_err, ifu_req_ready} !== 3'b001) begin
            errors++; $display("FAIL timeout_idle: ifu_resp/err/ifu_rdy got %b want 001", {ifu_resp_valid, resp_err, ifu_req_ready});
        end
        tick();
        ifu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; ifu_resp_ready = 1;
        tick(); tick();
        idle_inputs();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_ifu_single();
        test_round_robin();
        test_store_stall();
        test_resp_stall();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
